barcode_reader: RTL



---
 rtl/follower_pkg.sv | 17 +
 rtl/bc_sync.sv | 32 +++
 rtl/barcode_reader.sv | 130 +++++++++++++
 3 files changed

// File: rtl/follower_pkg.sv
// rtl/follower_pkg.sv - shared types and constants for the Follower barcode receiver
package follower_pkg;

    typedef enum logic [2:0] {
        BC_IDLE,
        BC_START_LOW,
        BC_WAIT_FALL,
        BC_BIT_TIME,
        BC_CHECK
    } bc_state_t;

    localparam int BC_TMR_W = 22;

    // Station IDs live in 0..63; a frame with either top bit set is rejected.
    localparam logic [1:0] BC_ID_MASK = 2'b00;

endpackage

// File: rtl/bc_sync.sv
// rtl/bc_sync.sv - two-flop synchronizer plus previous-value flop and edge detect
module bc_sync (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic sync,
    output logic fall,
    output logic rise
);

    logic meta;
    logic sync_q;
    logic prev;

    // Resync the idle-high line; reset to 1 so leaving reset never looks like an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta   <= 1'b1;
            sync_q <= 1'b1;
            prev   <= 1'b1;
        end else begin
            meta   <= raw;
            sync_q <= meta;
            prev   <= sync_q;
        end
    end

    assign sync = sync_q;
    assign fall = prev & ~sync_q;
    assign rise = ~prev & sync_q;

endmodule

// File: rtl/barcode_reader.sv
// rtl/barcode_reader.sv - self-calibrating station-ID barcode receiver
module barcode_reader
    import follower_pkg::*;
#(
    parameter int TMR_W = BC_TMR_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       BC,
    input  logic       clr_ID_vld,
    output logic [7:0] ID,
    output logic       ID_vld,
    output logic       busy
);

    localparam logic [TMR_W-1:0] TMR_ONE  = {{(TMR_W-1){1'b0}}, 1'b1};
    localparam logic [TMR_W-1:0] TMR_ONES = {TMR_W{1'b1}};

    logic            sync;
    logic            fall;
    logic            rise;

    bc_state_t       state;
    logic [TMR_W-1:0] timer;
    logic [TMR_W-1:0] period;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift_reg;

    // Four bit periods without a falling edge means the frame is lost; computed
    // two bits wider so a large period cannot wrap the limit.
    logic [TMR_W+1:0] lost_lim;
    logic             lost;
    logic             sample_pt;

    assign lost_lim  = {period, 2'b00};
    assign lost      = ({2'b00, timer} >= lost_lim) || (timer == TMR_ONES);
    assign sample_pt = (timer == period - TMR_ONE);

    bc_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .raw  (BC),
        .sync (sync),
        .fall (fall),
        .rise (rise)
    );

    // Frame FSM: measure the start pulse, then sample each bit one period after its falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= BC_IDLE;
            timer     <= '0;
            period    <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            ID        <= '0;
            ID_vld    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            // A set in CHECK below overrides this clear in the same cycle.
            if (clr_ID_vld) begin
                ID_vld <= 1'b0;
            end

            case (state)
                BC_IDLE: begin
                    if (fall) begin
                        timer <= '0;
                        state <= BC_START_LOW;
                        busy  <= 1'b1;
                    end
                end

                BC_START_LOW: begin
                    if (rise) begin
                        period  <= timer + TMR_ONE;
                        bit_cnt <= '0;
                        timer   <= '0;
                        state   <= BC_WAIT_FALL;
                    end else if (timer == TMR_ONES) begin
                        timer <= '0;
                        state <= BC_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        timer <= timer + TMR_ONE;
                    end
                end

                BC_WAIT_FALL: begin
                    if (fall) begin
                        timer <= '0;
                        state <= BC_BIT_TIME;
                    end else if (lost) begin
                        timer <= '0;
                        state <= BC_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        timer <= timer + TMR_ONE;
                    end
                end

                BC_BIT_TIME: begin
                    if (sample_pt) begin
                        shift_reg <= {shift_reg[6:0], sync};
                        bit_cnt   <= bit_cnt + 3'd1;
                        timer     <= '0;
                        state     <= (bit_cnt == 3'd7) ? BC_CHECK : BC_WAIT_FALL;
                    end else begin
                        timer <= timer + TMR_ONE;
                    end
                end

                BC_CHECK: begin
                    if (shift_reg[7:6] == BC_ID_MASK) begin
                        ID     <= shift_reg;
                        ID_vld <= 1'b1;
                    end
                    state <= BC_IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= BC_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
